// File: rtl/param_bram_pkg.sv
// -----------------------------------------------------------------------------
// param_bram_pkg
//   Shared definitions for the parameterised block RAM.
//   - state_t   : controller state (ST_INIT = sweep in progress, ST_RUN = serving
//                 requests)
//   - INIT_DESC : initialisation pattern, word i <= DEPTH-1-i (truncated)
//   - INIT_ZERO : initialisation pattern, every word <= 0
// -----------------------------------------------------------------------------
package param_bram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int INIT_DESC = 0;
    localparam int INIT_ZERO = 1;

endpackage

// File: rtl/param_bram_core.sv
// -----------------------------------------------------------------------------
// param_bram_core
//   Storage array with one write port and one synchronous read port, followed
//   by a read pipeline of RD_LAT stages. The array itself has no reset; only the
//   pipeline (valid bits and data registers) is reset.
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   synchronous active-high reset of the read pipeline only
//     wr_en     in   write mem[wr_addr] <= wr_data at this edge
//     wr_addr   in   ADDR_W write address
//     wr_data   in   DATA_W write data
//     rd_en     in   launch a read of mem[rd_addr] at this edge
//     rd_addr   in   ADDR_W read address
//     rd_valid  out  read data is on rd_data this cycle (RD_LAT cycles after rd_en)
//     rd_data   out  DATA_W read data; holds its value while rd_valid is low
// -----------------------------------------------------------------------------
module param_bram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Valid bit and data register per pipeline stage; the last stage drives the
    // outputs.
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Array write port, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read pipeline. Stage 0 samples the array at the accepting edge, so a
    // write accepted on the previous edge is already visible. A data register
    // only loads when its upstream stage carries a valid read, which makes the
    // final register hold its value between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                dat_q[0] <= mem[rd_addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rd_valid = vld_q[RD_LAT-1];
    assign rd_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/param_bram.sv
// -----------------------------------------------------------------------------
// param_bram
//   Parameterised single-port block RAM with a self-initialisation sweep.
//   After reset (or a clear pulse while running) the controller writes one word
//   per cycle for DEPTH cycles with the INIT_MODE pattern, then serves one read
//   or write request per cycle.
//
//   Parameters
//     DATA_W    word width
//     ADDR_W    address width, DEPTH = 2**ADDR_W
//     RD_LAT    read latency in cycles (1 or 2)
//     INIT_MODE INIT_DESC (word i = DEPTH-1-i) or INIT_ZERO
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset, overrides every other input
//     clear      in   one-cycle pulse, re-runs the sweep (ignored during a sweep)
//     req_valid  in   request present
//     req_write  in   1 = write, 0 = read
//     req_addr   in   word address
//     req_wdata  in   write data
//     req_ready  out  request accepted this cycle if req_valid
//     rsp_valid  out  rsp_data carries read data this cycle
//     rsp_data   out  read data, held while rsp_valid is low
//     init_busy  out  sweep in progress
//     dbg_state  out  current controller state
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready does not depend on req_valid, so the
//   requester may drop or change the request freely when req_ready is low.
//   There is no back-pressure on the response side: each accepted read yields
//   exactly one rsp_valid cycle, RD_LAT cycles later, in issue order.
// -----------------------------------------------------------------------------
module param_bram
    import param_bram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int INIT_MODE = INIT_DESC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_busy,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] cnt_inv;
    logic [DATA_W-1:0] init_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;

    // ~cnt over ADDR_W bits equals DEPTH-1-cnt; the cast then truncates or
    // zero-extends it to the word width.
    assign cnt_inv   = ~cnt_q;
    assign init_word = (INIT_MODE == INIT_ZERO) ? '0 : DATA_W'(cnt_inv);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        rd_en     = 1'b0;

        case (state_q)
            ST_INIT: begin
                // clear is deliberately not looked at here: a running sweep
                // is never restarted by it.
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = init_word;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    // The request presented alongside clear is dropped
                    // (req_ready is low); reads already in the pipeline
                    // carry on with the data they sampled.
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    if (req_write) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // Nothing may touch the array or launch a read on a reset edge.
        if (reset) begin
            mem_we = 1'b0;
            rd_en  = 1'b0;
        end
    end

    assign req_ready = (state_q == ST_RUN) && !clear;
    assign init_busy = (state_q == ST_INIT);
    assign dbg_state = state_q;

    param_bram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (mem_we),
        .wr_addr  (mem_addr),
        .wr_data  (mem_wdata),
        .rd_en    (rd_en),
        .rd_addr  (req_addr),
        .rd_valid (rsp_valid),
        .rd_data  (rsp_data)
    );

endmodule

// File: tb/tb_param_bram.sv
// -----------------------------------------------------------------------------
// tb_param_bram
//   Three instances share clock, reset and clear:
//     dut_a : defaults (8-bit data, 8-bit address, RD_LAT=1, descending init)
//     dut_b : as dut_a but RD_LAT=2, same request stream
//     dut_c : INIT_MODE=1, ADDR_W=4, DATA_W=16, own read stream
//   The reference model keeps the memory contents as arrays, the sweep as a
//   "words still to write" index, and remembers every accepted read per edge;
//   the expected response for latency L after edge k is the read accepted at
//   edge k-L+1, unless a reset happened in between.
// -----------------------------------------------------------------------------
module tb_param_bram;
  import param_bram_pkg::*;

  localparam int DEPTH  = 256;
  localparam int CDEPTH = 16;
  localparam int HIST   = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear;
  logic        req_valid, req_write;
  logic [7:0]  req_addr, req_wdata;
  logic        c_req_valid, c_req_write;
  logic [3:0]  c_req_addr;
  logic [15:0] c_req_wdata;

  logic        a_ready, a_rsp_valid, a_busy;
  logic [7:0]  a_rsp_data;
  state_t      a_state;
  logic        b_ready, b_rsp_valid, b_busy;
  logic [7:0]  b_rsp_data;
  state_t      b_state;
  logic        c_ready, c_rsp_valid, c_busy;
  logic [15:0] c_rsp_data;
  state_t      c_state;

  param_bram #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .INIT_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .init_busy(a_busy), .dbg_state(a_state));

  param_bram #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2), .INIT_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .init_busy(b_busy), .dbg_state(b_state));

  param_bram #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .INIT_MODE(1)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(c_req_valid),
    .req_write(c_req_write), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
    .req_ready(c_ready), .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data),
    .init_busy(c_busy), .dbg_state(c_state));

  // reference model state
  logic [7:0]  m_mem [DEPTH];
  logic [15:0] mc_mem [CDEPTH];
  bit          m_run, mc_run, m_known;
  int          m_idx, mc_idx;
  bit          hv [HIST];
  logic [7:0]  hd [HIST];
  bit          chv [HIST];
  logic [15:0] chd [HIST];
  int          edge_n, flush_n;
  logic [7:0]  last_a, last_b;
  logic [15:0] last_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt, c_busy_cnt;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One clock: check combinational ready, advance the model, take the edge,
  // check every registered output.
  task automatic step();
    bit acc, cacc, va, vb, vc;
    int ib;
    #1;
    if (m_known) begin
      chk1("a_ready", a_ready, m_run && !clear);
      chk1("b_ready", b_ready, m_run && !clear);
      chk1("c_ready", c_ready, mc_run && !clear);
    end
    acc  = !reset && m_run && !clear && req_valid;
    cacc = !reset && mc_run && !clear && c_req_valid;
    hv[edge_n]  = acc && !req_write;
    hd[edge_n]  = m_mem[req_addr];
    chv[edge_n] = cacc && !c_req_write;
    chd[edge_n] = mc_mem[c_req_addr];
    if (reset) begin
      m_run = 0; m_idx = 0; mc_run = 0; mc_idx = 0;
      flush_n = edge_n; last_a = '0; last_b = '0; last_c = '0;
      m_known = 1;
    end else begin
      if (!m_run) begin
        m_mem[m_idx] = 8'(DEPTH - 1 - m_idx);
        m_idx++;
        if (m_idx == DEPTH) begin m_run = 1; m_idx = 0; end
      end else if (clear) begin
        m_run = 0; m_idx = 0;
      end else if (acc && req_write) begin
        m_mem[req_addr] = req_wdata;
      end
      if (!mc_run) begin
        mc_mem[mc_idx] = 16'h0000;
        mc_idx++;
        if (mc_idx == CDEPTH) begin mc_run = 1; mc_idx = 0; end
      end else if (clear) begin
        mc_run = 0; mc_idx = 0;
      end else if (cacc && c_req_write) begin
        mc_mem[c_req_addr] = c_req_wdata;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      va = (edge_n > flush_n) && hv[edge_n];
      if (va) last_a = hd[edge_n];
      ib = edge_n - 1;
      vb = (ib > flush_n) && hv[ib];
      if (vb) last_b = hd[ib];
      vc = (edge_n > flush_n) && chv[edge_n];
      if (vc) last_c = chd[edge_n];
      chk1("a_busy", a_busy, !m_run);
      chk1("b_busy", b_busy, !m_run);
      chk1("c_busy", c_busy, !mc_run);
      chk1("a_state", a_state == ST_RUN, m_run);
      chk1("b_state", b_state == ST_RUN, m_run);
      chk1("c_state", c_state == ST_RUN, mc_run);
      chk1("a_rsp_valid", a_rsp_valid, va);
      chk8("a_rsp_data", a_rsp_data, last_a);
      chk1("b_rsp_valid", b_rsp_valid, vb);
      chk8("b_rsp_data", b_rsp_data, last_b);
      chk1("c_rsp_valid", c_rsp_valid, vc);
      chk16("c_rsp_data", c_rsp_data, last_c);
    end
    edge_n++;
  endtask

  task automatic idle();
    req_valid = 0; req_write = 0; clear = 0; c_req_valid = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    req_valid = 1; req_write = 0; req_addr = a;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1; req_write = 1; req_addr = a; req_wdata = d;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      clear     = 0;
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = ($urandom_range(0, 3) == 0);
      req_addr  = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      req_wdata = 8'($urandom_range(0, 255));
      c_req_valid = ($urandom_range(0, 1) != 0);
      c_req_addr  = 4'($urandom_range(0, 15));
      step();
    end
    idle();
  endtask

  // Counts sweep cycles starting from the sample just taken after a reset or
  // clear edge; busy must read high for exactly DEPTH samples.
  task automatic count_sweep(input int clear_at);
    busy_cnt = int'(a_busy);
    for (int i = 0; i < DEPTH + 4; i++) begin
      clear = (i == clear_at);
      step();
      busy_cnt += int'(a_busy);
    end
    idle();
    chk16("sweep_len", 16'(busy_cnt), 16'(DEPTH));
  endtask

  initial begin
    m_known = 0; m_run = 0; mc_run = 0; m_idx = 0; mc_idx = 0;
    edge_n = 0; flush_n = 0;
    last_a = '0; last_b = '0; last_c = '0;
    req_addr = '0; req_wdata = '0; c_req_addr = '0; c_req_wdata = '0; c_req_write = 0;
    idle();

    // reset, then full sweep on both sizes
    reset = 1;
    step();
    reset = 0;
    busy_cnt   = int'(a_busy);
    c_busy_cnt = int'(c_busy);
    for (int i = 0; i < DEPTH + 4; i++) begin
      step();
      busy_cnt   += int'(a_busy);
      c_busy_cnt += int'(c_busy);
    end
    chk16("sweep_len_a", 16'(busy_cnt), 16'(DEPTH));
    chk16("sweep_len_c", 16'(c_busy_cnt), 16'(CDEPTH));

    // first reads after the sweep
    rd(8'h00); step();
    chk1("rd00_valid", a_rsp_valid, 1'b1);
    chk8("rd00_data", a_rsp_data, 8'hFF);
    rd(8'h10); step();
    chk8("rd10_data", a_rsp_data, 8'hEF);
    chk8("b_rd00_data", b_rsp_data, 8'hFF);
    idle(); step(); step();

    // write then read the same address on the next cycle
    wr(8'h3C, 8'hA5); step();
    chk1("wr_no_rsp_a", a_rsp_valid, 1'b0);
    rd(8'h3C); step();
    chk1("wr_no_rsp_b", b_rsp_valid, 1'b0);
    chk8("raw_3c", a_rsp_data, 8'hA5);
    idle(); step(); step();

    // four back-to-back reads, checked on the two-cycle instance
    for (int i = 0; i < 6; i++) begin
      if (i < 4) rd(8'(i)); else idle();
      step();
      if (i >= 1 && i <= 4) begin
        chk1("b2b_valid", b_rsp_valid, 1'b1);
        chk8("b2b_data", b_rsp_data, 8'(8'hFF - (i - 1)));
      end else begin
        chk1("b2b_idle", b_rsp_valid, 1'b0);
      end
    end
    idle(); step();

    random_traffic(300);
    step();

    // reset 100 cycles into a sweep restarts it from address 0
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 100; i++) step();
    reset = 1; step(); reset = 0;
    count_sweep(-1);
    rd(8'h3C); step();
    chk8("post_reset_3c", a_rsp_data, 8'hC3);
    idle();
    random_traffic(40);
    step();

    // clear with a read pending: the read is dropped, the sweep restores 0xC3;
    // a second clear 50 cycles into the sweep is ignored
    wr(8'h3C, 8'hA5); step();
    rd(8'h3C); clear = 1; step();
    chk1("clr_drop", a_rsp_valid, 1'b0);
    idle();
    count_sweep(50);
    rd(8'h3C); step();
    chk8("post_clear_3c", a_rsp_data, 8'hC3);
    idle(); step();

    // read in flight when clear is taken completes with pre-clear data
    wr(8'h05, 8'h77); step();
    rd(8'h05); step();
    chk8("inflight_a", a_rsp_data, 8'h77);
    idle(); clear = 1; step();
    chk1("inflight_b_valid", b_rsp_valid, 1'b1);
    chk8("inflight_b_data", b_rsp_data, 8'h77);
    idle();
    count_sweep(-1);

    random_traffic(200);
    c_req_valid = 1; c_req_addr = 4'hF; step();
    chk1("c_rdf_valid", c_rsp_valid, 1'b1);
    chk16("c_rdf_data", c_rsp_data, 16'h0000);
    idle(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_bram.md
PARAM_BRAM -- requirements
Module: param_bram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1 or 2).
REQ-004 SHALL have parameter INIT_MODE, default 0: 0 = word i initialised to DEPTH-1-i (truncated to DATA_W); 1 = all zero.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port clear  input  1  one-cycle pulse requesting memory re-initialisation.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W  word address.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 SHALL have port req_ready  output  1  request accepted this cycle if req_valid.
REQ-013 SHALL have port rsp_valid  output  1  rsp_data carries read data this cycle.
REQ-014 SHALL have port rsp_data  output  DATA_W  read data.
REQ-015 SHALL have port init_busy  output  1  initialisation sweep in progress.

Function
REQ-016 SHALL implement FSM states ST_INIT and ST_RUN.
REQ-017 ST_INIT SHALL write one word per cycle at address counter 0..DEPTH-1 with INIT_MODE pattern, then enter ST_RUN after writing DEPTH-1 (exactly DEPTH cycles).
REQ-018 init_busy SHALL equal (state == ST_INIT).
REQ-019 req_ready SHALL be combinational: (state == ST_RUN) and not clear.
REQ-020 Accepted read (req_valid, req_ready, !req_write) SHALL drive rsp_valid=1 and rsp_data=mem[req_addr] exactly RD_LAT cycles later.
REQ-021 Accepted write SHALL update mem[req_addr] at that edge and SHALL NOT raise rsp_valid.
REQ-022 Reads SHALL sustain one per cycle; back-to-back responses in issue order, no bubbles.
REQ-023 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 rsp_data SHALL hold its last value while rsp_valid is 0.
REQ-025 clear in ST_RUN SHALL move to ST_INIT with counter 0 next cycle; request presented that cycle SHALL be dropped (req_ready=0).
REQ-026 clear in ST_INIT SHALL be ignored (sweep continues, not restarted).
REQ-027 Reads already in the read pipeline when clear is taken SHALL complete with pre-clear data.

Reset
REQ-028 reset SHALL take priority over all inputs including clear.
REQ-029 On reset: state=ST_INIT, counter=0, rsp_valid=0, rsp_data=0, read pipeline flushed; init_busy=1 and req_ready=0 the following cycle.
REQ-030 reset asserted mid-sweep SHALL restart the sweep at address 0 (full DEPTH cycles).
REQ-031 Memory array SHALL have no reset port; contents are defined only by the sweep.

Structure
REQ-032 Package param_bram_pkg SHALL hold the state enum (ST_INIT, ST_RUN) and INIT_MODE constants (INIT_DESC=0, INIT_ZERO=1).
REQ-033 Storage array plus RD_LAT read pipeline SHALL be sub-module param_bram_core (single write port, synchronous read, no reset on array); FSM and muxing in top.

Verification (defaults unless stated)
REQ-034 reset 1 cycle -> init_busy high exactly 256 cycles; then read 0x00 -> 0xFF, read 0x10 -> 0xEF, 1 cycle later.
REQ-035 write 0xA5 @0x3C, read 0x3C next cycle -> rsp_data 0xA5; rsp_valid never high for the write.
REQ-036 RD_LAT=2, reads 0x00..0x03 on consecutive cycles -> rsp_valid 4 consecutive cycles, 0xFF,0xFE,0xFD,0xFC, first 2 cycles after issue.
REQ-037 reset at sweep cycle 100 -> init_busy stays high 256 further cycles; reads afterwards match pattern.
REQ-038 after 0xA5 @0x3C, pulse clear with read 0x3C pending -> request dropped, 256-cycle sweep, then read 0x3C -> 0xC3.
REQ-039 INIT_MODE=1, ADDR_W=4, DATA_W=16 -> init_busy 16 cycles; every read returns 0x0000.
